// File: rtl/morph_pkg.sv
// Shared definitions for the binary morphology stream blocks.
package morph_pkg;

  localparam int DEF_WIDTH  = 9;
  localparam int DEF_HEIGHT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/erosion_line_buffer.sv
// Two-row delay line for a 1-bit raster stream.
// tap_row1 is the pixel one row back and tap_row2 the pixel two rows back.
module erosion_line_buffer
  import morph_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic shift,
  input  logic pixel,
  output logic tap_row1,
  output logic tap_row2
);

  // Contents need no reset: every frame rewrites them before any unmasked use.
  logic [2*WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (shift) begin
      sr <= {sr[2*WIDTH-2:0], pixel};
    end
  end

  assign tap_row1 = sr[WIDTH-1];
  assign tap_row2 = sr[2*WIDTH-1];

endmodule

// File: rtl/erosion3x3_stream.sv
// Streaming 3x3 binary erosion over WIDTH x HEIGHT frames with a zeroed border.
// Input handshake: a pixel moves when i_pixel_valid && i_ready; i_ready drops only during FLUSH.
module erosion3x3_stream
  import morph_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_pixel,
  input  logic   i_pixel_valid,
  input  logic   i_sop,
  output logic   i_ready,
  output logic   o_pixel,
  output logic   o_pixel_valid,
  output logic   o_sop,
  output logic   o_eop,
  output state_e fsm_state
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int IDX_W = $clog2(NPIX);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  localparam logic [IDX_W-1:0] K_FILL_END = IDX_W'(WIDTH);
  localparam logic [IDX_W-1:0] K_LAST     = IDX_W'(NPIX - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(HEIGHT - 1);

  state_e           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [COL_W-1:0] out_col;
  logic [ROW_W-1:0] out_row;

  logic accept, restart, shift, emit, new_pix;
  logic tap_row1, tap_row2, and9, interior, first_out, last_out;
  logic [1:0] win_top, win_mid, win_bot;

  assign i_ready   = (state != FLUSH);
  assign accept    = i_pixel_valid & i_ready;
  assign restart   = accept & i_sop;
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    shift      = 1'b0;
    emit       = 1'b0;
    if (restart) begin
      // A new start of frame always wins, even mid-frame; any pending output is dropped.
      state_next = FILL;
      idx_next   = IDX_W'(1);
      shift      = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        FILL: begin
          if (accept) begin
            shift    = 1'b1;
            idx_next = idx + IDX_W'(1);
            if (idx == K_FILL_END) state_next = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            shift = 1'b1;
            emit  = 1'b1;
            if (idx == K_LAST) begin
              state_next = FLUSH;
              idx_next   = '0;
            end else begin
              idx_next = idx + IDX_W'(1);
            end
          end
        end
        FLUSH: begin
          shift = 1'b1;
          emit  = 1'b1;
          if (last_out) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign new_pix = (state == FLUSH) ? 1'b0 : i_pixel;

  erosion_line_buffer #(
    .WIDTH(WIDTH)
  ) u_line_buffer (
    .clk      (clk),
    .shift    (shift),
    .pixel    (new_pix),
    .tap_row1 (tap_row1),
    .tap_row2 (tap_row2)
  );

  // Window columns: [0] holds the previous pixel column, [1] the one before it.
  always_ff @(posedge clk) begin
    if (shift) begin
      win_top <= {win_top[0], tap_row2};
      win_mid <= {win_mid[0], tap_row1};
      win_bot <= {win_bot[0], new_pix};
    end
  end

  assign and9 = &{tap_row2, win_top, tap_row1, win_mid, new_pix, win_bot};
  assign interior  = (out_row != '0) && (out_row != ROW_LAST) &&
                     (out_col != '0) && (out_col != COL_LAST);
  assign first_out = (out_row == '0) && (out_col == '0);
  assign last_out  = (out_row == ROW_LAST) && (out_col == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      out_col <= '0;
      out_row <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (restart) begin
        out_col <= '0;
        out_row <= '0;
      end else if (emit) begin
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == ROW_LAST) ? '0 : out_row + ROW_W'(1);
        end else begin
          out_col <= out_col + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_pixel_valid <= 1'b0;
      o_pixel       <= 1'b0;
      o_sop         <= 1'b0;
      o_eop         <= 1'b0;
    end else begin
      o_pixel_valid <= emit;
      o_pixel       <= emit & and9 & interior;
      o_sop         <= emit & first_out;
      o_eop         <= emit & last_out;
    end
  end

endmodule

// File: doc/erosion3x3_stream.md
EROSION3X3_STREAM -- requirements
Module: erosion3x3_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 9, giving pixels per row (at least 3).
REQ-002 SHALL have parameter HEIGHT, default 6, giving rows per frame (at least 3).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_pixel, input, 1 bit: binary mask pixel, raster order.
REQ-006 SHALL have port i_pixel_valid, input, 1 bit: i_pixel is offered this cycle.
REQ-007 SHALL have port i_sop, input, 1 bit: qualifies pixel 0 of a frame; meaningful only with i_pixel_valid.
REQ-008 SHALL have port i_ready, output, 1 bit: block accepts input; a pixel is accepted only when i_pixel_valid and i_ready are both high.
REQ-009 SHALL have port o_pixel, output, 1 bit: eroded pixel.
REQ-010 SHALL have port o_pixel_valid, output, 1 bit: o_pixel is valid this cycle.
REQ-011 SHALL have ports o_sop and o_eop, outputs, 1 bit each: flag output pixel 0 and output pixel WIDTH*HEIGHT-1 of a frame.

Function
REQ-012 SHALL implement a four-state FSM with states IDLE, FILL, RUN and FLUSH.
REQ-013 SHALL, in IDLE, drop all accepted pixels without i_sop; an accepted pixel with i_sop SHALL be stored as k=0 and move the FSM to FILL.
REQ-014 SHALL, in FILL, accept pixels k=1..WIDTH without producing output; accepting k=WIDTH SHALL move the FSM to RUN.
REQ-015 SHALL, in RUN, produce exactly one output (index k-WIDTH-1) for each accepted pixel k, registered so it is valid on the cycle after acceptance.
REQ-016 SHALL move from RUN to FLUSH after accepting k=WIDTH*HEIGHT-1.
REQ-017 SHALL, in FLUSH, hold i_ready low, shift zeros into the window, and emit one output per cycle for WIDTH+1 cycles, then return to IDLE.
REQ-018 SHALL hold i_ready high in IDLE, FILL and RUN.
REQ-019 SHALL emit exactly WIDTH*HEIGHT outputs per completed frame.
REQ-020 SHALL compute output (r,c) as the AND of the 3x3 neighbourhood centred on input (r,c) when 1 <= r <= HEIGHT-2 and 1 <= c <= WIDTH-2.
REQ-021 SHALL force border outputs (first or last row or column) to 0.
REQ-022 SHALL assert o_sop together with output 0 and o_eop together with output WIDTH*HEIGHT-1, each for exactly one valid cycle.
REQ-023 SHALL hold o_pixel, o_sop and o_eop at 0 whenever o_pixel_valid is 0.
REQ-024 SHALL treat an accepted i_sop in FILL or RUN as aborting the current frame: no o_eop for the aborted frame, the pixel becomes k=0, the FSM enters FILL, and any pending registered output on that cycle is suppressed.
REQ-025 SHALL leave state and counters unchanged on cycles where i_pixel_valid is low in FILL or RUN (gaps allowed).
REQ-026 SHALL size counters as $clog2(WIDTH*HEIGHT) for the frame index and $clog2(WIDTH) for the column; wrap is never reached except via REQ-016.

Reset
REQ-027 SHALL, while rst is high at a clock edge, set the FSM to IDLE, clear all counters and set o_pixel_valid, o_pixel, o_sop and o_eop to 0.
REQ-028 SHALL drive i_ready high on the cycle after reset.
REQ-029 SHALL let line-buffer contents survive reset (they need no reset, since FILL rewrites them).
REQ-030 SHALL, on reset mid-frame, discard the frame with no further outputs.

Structure
REQ-031 SHALL define the FSM state enum and the default WIDTH and HEIGHT in the shared package morph_pkg.
REQ-032 SHALL place the two-row delay (2*WIDTH shift register with row taps, clock-enabled by a shift strobe) in sub-module erosion_line_buffer.
REQ-033 SHALL keep the 3x3 window registers, border masking and FSM in the top module.

Verification
REQ-034 SHALL cover: all-ones 9x6 frame -> 54 outputs; 28 ones exactly at rows 1-4, cols 1-7; o_sop on the first output, o_eop on the 54th.
REQ-035 SHALL cover: all-ones frame with input (2,4)=0 -> interior zeros at rows 1-3, cols 3-5; all other interior outputs are 1.
REQ-036 SHALL cover: random valid gaps of 0-3 cycles -> output sequence identical to the gapless run, with i_ready low for exactly 10 cycles per frame.
REQ-037 SHALL cover: i_sop reasserted at k=20 -> no o_eop for frame 1; the next 54 outputs match a fresh frame.
REQ-038 SHALL cover: rst asserted at k=30 -> o_pixel_valid 0 from the next cycle; pixels without i_sop ignored; the next frame is correct.
REQ-039 SHALL cover: back-to-back frames, with i_sop offered during FLUSH held until i_ready is high -> both frames correct.
